// File: rtl/aes_lite_decrypt.sv
// Byte decryptor: ROUNDS inverse XOR rounds (rc counts ROUNDS-1 down to 0) between valid/ready handshakes.
// Optional build macro AES_LITE_DEC_BACK2BACK_EN lets DONE accept the next byte while emitting the result.
module aes_lite_decrypt #(
    parameter int ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] cipher_in,
    input  logic [7:0] key_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] plain_out,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [3:0] RC_LAST = 4'(ROUNDS - 1);

    state_t     state_reg, state_next;
    logic [3:0] rc_reg, rc_next;
    logic [7:0] st_reg, st_next;
    logic [7:0] key_reg, key_next;
    logic [7:0] plain_reg, plain_next;
    logic [7:0] round_mix;
    logic       accept_in;

    // The round constant only touches the low nibble of the state.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mix
            if (gi < 4) begin : g_lo
                assign round_mix[gi] = st_reg[gi] ^ key_reg[gi] ^ rc_reg[gi];
            end else begin : g_hi
                assign round_mix[gi] = st_reg[gi] ^ key_reg[gi];
            end
        end
    endgenerate

`ifdef AES_LITE_DEC_BACK2BACK_EN
    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
`else
    assign in_ready = (state_reg == IDLE);
`endif

    assign accept_in = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign plain_out = plain_reg;

    always_comb begin
        state_next = state_reg;
        rc_next    = rc_reg;
        st_next    = st_reg;
        key_next   = key_reg;
        plain_next = plain_reg;
        case (state_reg)
            IDLE: begin
                if (accept_in) begin
                    st_next    = cipher_in;
                    key_next   = key_in;
                    rc_next    = RC_LAST;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                st_next = round_mix;
                if (rc_reg == 4'd0) begin
                    plain_next = round_mix;
                    state_next = DONE;
                end else begin
                    rc_next = rc_reg - 4'd1;
                end
            end
            DONE: begin
                // accept_in can only be set here when back-to-back loading is built in.
                if (out_ready) begin
                    if (accept_in) begin
                        st_next    = cipher_in;
                        key_next   = key_in;
                        rc_next    = RC_LAST;
                        state_next = ROUND;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rc_reg    <= 4'd0;
            st_reg    <= 8'd0;
            key_reg   <= 8'd0;
            plain_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            rc_reg    <= rc_next;
            st_reg    <= st_next;
            key_reg   <= key_next;
            plain_reg <= plain_next;
        end
    end
endmodule
